// File: rtl/tx_quiesce_pkg.sv
// Shared types for the TX quiesce monitor.
package tx_quiesce_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        QUIET  = 2'd3
    } qstate_e;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/updown_cnt.sv
// Up/down occupancy counter: simultaneous inc/dec cancel, a decrement at
// zero holds the count and raises a sticky underflow flag.
module updown_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         next_zero,
    output logic         underflow
);

    logic [W-1:0] count_next;
    logic         under_evt;

    always_comb begin
        count_next = count;
        under_evt  = 1'b0;
        if (inc && !dec) begin
            count_next = count + W'(1);
        end else if (dec && !inc) begin
            if (count == '0) begin
                under_evt = 1'b1;
            end else begin
                count_next = count - W'(1);
            end
        end
    end

    // Lets the owner react in the same cycle the last completion lands.
    assign next_zero = (count_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            count <= count_next;
            if (under_evt) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_quiesce_mon.sv
// TX quiesce monitor: gates DMA launches on halt, waits for in-flight
// transfers to drain and the datapath to settle, then reports tx_quiet.
module tx_quiesce_mon
    import tx_quiesce_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16,
    parameter int SETTLE_CYCLES   = 8,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dma_halt,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          cpl_valid,
    output logic          tx_quiet,
    output logic [CW-1:0] outstanding,
    output logic          err_underflow
);

    localparam logic [CW-1:0]      MAX_CNT     = CW'(MAX_OUTSTANDING);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);

    qstate_e              state, state_next;
    logic [TIMER_W-1:0]   timer, timer_next;
    logic                 launch;
    logic                 cnt_next_zero;

    // Combinational so a halt blocks launches in the very cycle it rises.
    assign req_ready = (state == RUN) && !dma_halt && (outstanding < MAX_CNT);
    assign launch    = req_valid && req_ready;
    assign tx_quiet  = (state == QUIET);

    updown_cnt #(
        .W(CW)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (launch),
        .dec       (cpl_valid),
        .count     (outstanding),
        .next_zero (cnt_next_zero),
        .underflow (err_underflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        unique case (state)
            RUN: begin
                if (dma_halt) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!dma_halt) begin
                    state_next = RUN;
                end else if (cnt_next_zero) begin
                    state_next = SETTLE;
                    timer_next = '0;
                end
            end
            SETTLE: begin
                if (!dma_halt) begin
                    state_next = RUN;
                end else begin
                    timer_next = timer + TIMER_W'(1);
                    if (timer == SETTLE_LAST && outstanding == '0) begin
                        state_next = QUIET;
                    end
                end
            end
            QUIET: begin
                if (!dma_halt) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_tx_quiesce_mon.sv
// Self-checking bench for tx_quiesce_mon (MAX_OUTSTANDING=4, SETTLE_CYCLES=8).
module tb_tx_quiesce_mon;

    logic       clk = 1'b0;
    logic       rst, dma_halt, req_valid, cpl_valid;
    logic       req_ready, tx_quiet, err_underflow;
    logic [2:0] outstanding;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic r, h, v, c;
        logic chk_rdy, rdy;
        logic q;
        int   n;
        logic e;
    } vec_t;

    typedef struct {
        logic  q;
        int    n;
        logic  e;
        string name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    tx_quiesce_mon #(
        .MAX_OUTSTANDING(4),
        .SETTLE_CYCLES(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dma_halt     (dma_halt),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .cpl_valid    (cpl_valid),
        .tx_quiet     (tx_quiet),
        .outstanding  (outstanding),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, h, v, c, chk_rdy, rdy, q,
                                input int n, input logic e);
        vec_t t;
        t.r = r; t.h = h; t.v = v; t.c = c;
        t.chk_rdy = chk_rdy; t.rdy = rdy; t.q = q; t.n = n; t.e = e;
        return t;
    endfunction

    // Drive one cycle, check req_ready before the edge, check registered outputs after it.
    task automatic step(input vec_t t, input string name);
        exp_t x;
        rst = t.r; dma_halt = t.h; req_valid = t.v; cpl_valid = t.c;
        #1;
        if (t.chk_rdy) chk({name, "_ready"}, {31'b0, req_ready}, {31'b0, t.rdy});
        x.q = t.q; x.n = t.n; x.e = t.e; x.name = name;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({x.name, "_quiet"}, {31'b0, tx_quiet}, {31'b0, x.q});
        chk({x.name, "_cnt"}, {29'b0, outstanding}, x.n);
        chk({x.name, "_err"}, {31'b0, err_underflow}, {31'b0, x.e});
    endtask

    task automatic do_reset(input string name);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), name);
    endtask

    initial begin
        rst = 1'b1; dma_halt = 1'b0; req_valid = 1'b0; cpl_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset");
        chk("reset_ready", {31'b0, req_ready}, 32'd1);

        //            r  h  v  c  ck rdy q  n  e
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 3, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 4, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Halt with no traffic: quiet from cycle 10; a late completion in QUIET only flags underflow.
        for (int k = 0; k < 14; k++)
            step(mk(0, 1, 0, (k == 11), 1, 0, (k >= 9), 0, (k >= 11)), $sformatf("idle_halt%0d", k));
        step(mk(0, 0, 0, 0, 1, 0, 0, 0, 1), "idle_release");
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 1), "idle_run");
        do_reset("reset_b");

        // Three in flight, completions at halt cycles 4, 7, 12: quiet from cycle 21.
        for (int k = 0; k < 3; k++) step(mk(0, 0, 1, 0, 1, 1, 0, k + 1, 0), $sformatf("c_launch%0d", k));
        for (int k = 0; k < 26; k++)
            step(mk(0, 1, 1, (k == 4 || k == 7 || k == 12), 1, 0, (k >= 20),
                    (k >= 12) ? 0 : (k >= 7) ? 1 : (k >= 4) ? 2 : 3, 0),
                 $sformatf("drain%0d", k));
        step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "drain_release");
        step(mk(0, 0, 1, 0, 1, 1, 0, 1, 0), "drain_run");
        do_reset("reset_c");

        // Halt dropped in SETTLE at cycle 5: RUN in cycle 6, quiet never rises.
        for (int k = 0; k < 5; k++) step(mk(0, 1, 0, 0, 1, 0, 0, 0, 0), $sformatf("abort%0d", k));
        step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "abort5");
        for (int k = 6; k < 16; k++) step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0), $sformatf("abort%0d", k));

        // One-cycle halt: RUN -> DRAIN -> RUN.
        step(mk(0, 1, 0, 0, 1, 0, 0, 0, 0), "pulse0");
        step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "pulse1");
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0), "pulse2");

        // Reset during DRAIN with two outstanding.
        step(mk(0, 0, 1, 0, 1, 1, 0, 1, 0), "rstd_l0");
        step(mk(0, 0, 1, 0, 1, 1, 0, 2, 0), "rstd_l1");
        step(mk(0, 1, 0, 0, 1, 0, 0, 2, 0), "rstd_halt");
        step(mk(1, 1, 0, 0, 1, 0, 0, 0, 0), "rstd_rst");
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0), "rstd_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
